// File: rtl/case_preserving_stream_cipher_pkg.sv
// Shared constants and enumerations for the case-preserving stream cipher.
package case_preserving_stream_cipher_pkg;

  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UZ = 8'h5A;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LZ = 8'h7A;
  localparam logic [7:0] CASE_OFS = 8'd32;
  localparam logic [5:0] ALPHA_N  = 6'd26;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/case_preserving_stream_cipher_if.sv
// Byte stream in/out bundle: upstream valid/ready and downstream valid/ready.
interface case_preserving_stream_cipher_if;

  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  // Traffic generator / consumer side
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  // Cipher engine side
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/case_preserving_stream_cipher_shift_unit.sv
// Combinational Vigenere shift of one ASCII byte; keeps letter case, passes non-letters.
module case_preserving_stream_cipher_shift_unit
  import case_preserving_stream_cipher_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic [7:0] key_byte,   // always an uppercase letter
  input  mode_e      mode,
  output logic [7:0] out_byte,
  output logic       is_alpha
);

  logic       is_up;
  logic       is_lo;
  logic [7:0] up_byte;
  logic [5:0] p;
  logic [5:0] k;
  logic [5:0] sum;

  // Fold to uppercase, add/subtract key offset mod 26, restore case
  always_comb begin
    is_up    = (in_byte >= ASCII_UA) && (in_byte <= ASCII_UZ);
    is_lo    = (in_byte >= ASCII_LA) && (in_byte <= ASCII_LZ);
    is_alpha = is_up || is_lo;
    up_byte  = is_lo ? (in_byte - CASE_OFS) : in_byte;
    p        = 6'(up_byte - ASCII_UA);
    k        = 6'(key_byte - ASCII_UA);
    sum      = (mode == MODE_DEC) ? (p + ALPHA_N - k) : (p + k);
    // Both operands are below 26, so one conditional subtract suffices
    if (sum >= ALPHA_N) begin
      sum = sum - ALPHA_N;
    end
    out_byte = in_byte;
    if (is_alpha) begin
      out_byte = ASCII_UA + {2'b00, sum} + (is_lo ? CASE_OFS : 8'd0);
    end
  end

endmodule

// File: rtl/case_preserving_stream_cipher.sv
// Streaming Vigenere cipher: key registers, message FSM, key index and output register.
module case_preserving_stream_cipher
  import case_preserving_stream_cipher_pkg::*;
#(
  parameter int unsigned KEY_LEN = 7,
  parameter int unsigned IDX_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_wr_en,
  input  logic [IDX_W-1:0]     key_wr_idx,
  input  logic [7:0]           key_wr_data,
  output logic                 key_err,
  input  logic                 mode,
  case_preserving_stream_cipher_if.slave bus,
  output logic                 busy
);

  localparam logic [IDX_W:0]   KeyLenW = (IDX_W + 1)'(KEY_LEN);
  localparam logic [IDX_W-1:0] KeyLast = IDX_W'(KEY_LEN - 1);

  logic [7:0]       key_q [KEY_LEN];
  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, cur_mode;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             key_err_q, key_err_d;
  logic             m_valid_q, m_last_q;
  logic [7:0]       m_data_q;

  logic             accept;
  logic [7:0]       cipher_byte;
  logic             byte_alpha;
  logic             key_up, key_lo, key_wr_ok;
  logic [7:0]       key_norm;

  assign bus.s_ready = !m_valid_q || bus.m_ready;
  assign accept      = bus.s_valid && bus.s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign key_err     = key_err_q;
  assign busy        = (state_q == ST_RUN);

  // First beat of a message uses the live mode input; later beats use the latched one
  assign cur_mode = (state_q == ST_IDLE) ? mode_e'(mode) : mode_q;

  case_preserving_stream_cipher_shift_unit u_shift (
    .in_byte  (bus.s_data),
    .key_byte (key_q[idx_q]),
    .mode     (cur_mode),
    .out_byte (cipher_byte),
    .is_alpha (byte_alpha)
  );

  // Key write qualification, normalisation to uppercase and sticky error
  always_comb begin
    key_up    = (key_wr_data >= ASCII_UA) && (key_wr_data <= ASCII_UZ);
    key_lo    = (key_wr_data >= ASCII_LA) && (key_wr_data <= ASCII_LZ);
    key_wr_ok = key_wr_en && (state_q == ST_IDLE) && !accept && ({1'b0, key_wr_idx} < KeyLenW);
    key_norm  = ASCII_UA;
    if (key_up) begin
      key_norm = key_wr_data;
    end else if (key_lo) begin
      key_norm = key_wr_data - CASE_OFS;
    end
    key_err_d = key_err_q;
    if (key_wr_en && (!key_wr_ok || !(key_up || key_lo))) begin
      key_err_d = 1'b1;
    end
  end

  // Message FSM next state, mode latch and key index advance/clear
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d = mode_e'(mode);
          if (!bus.s_last) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept && bus.s_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (bus.s_last) begin
        idx_d = '0;
      end else if (byte_alpha) begin
        idx_d = (idx_q == KeyLast) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ENC;
      idx_q     <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      key_err_q <= key_err_d;
    end
  end

  // Key storage; "A" in every slot makes the cipher an identity
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < KEY_LEN; i++) begin
      if (!rst_n) begin
        key_q[i] <= ASCII_UA;
      end else if (key_wr_ok && (key_wr_idx == IDX_W'(i))) begin
        key_q[i] <= key_norm;
      end
    end
  end

  // Single output register; holds while the sink stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= 8'd0;
      m_last_q  <= 1'b0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= cipher_byte;
      m_last_q  <= bus.s_last;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_case_preserving_stream_cipher.sv
// Randomised bench for case_preserving_stream_cipher against a behavioural cipher model.
module tb_case_preserving_stream_cipher;

  localparam int unsigned KeyLen = 3;
  localparam int unsigned IdxW   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            key_wr_en;
  logic [IdxW-1:0] key_wr_idx;
  logic [7:0]      key_wr_data;
  logic            key_err;
  logic            mode;
  logic            busy;

  case_preserving_stream_cipher_if bus_if ();

  case_preserving_stream_cipher #(
    .KEY_LEN (KeyLen)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .key_err     (key_err),
    .mode        (mode),
    .bus         (bus_if),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_check = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_check++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] mdl_key [KeyLen];
  int         mdl_idx;
  bit         mdl_run;
  bit         mdl_err;
  bit         mdl_dec;
  logic [8:0] exp_q [$];
  logic [7:0] cap [$];

  // Driver controls
  int hold_n   = 0;
  int stalls   = 0;
  bit rdy_rand = 0;
  bit rand_mix = 0;

  function automatic bit is_letter(logic [7:0] c);
    return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
  endfunction

  function automatic logic [7:0] ref_cipher(logic [7:0] c, logic [7:0] kb, bit dec);
    int k, base, p;
    k = int'(kb) - 65;
    if (c >= 8'd65 && c <= 8'd90) base = 65;
    else if (c >= 8'd97 && c <= 8'd122) base = 97;
    else return c;
    p = int'(c) - base;
    return 8'(base + (p + (dec ? 26 - k : k)) % 26);
  endfunction

  function automatic logic [63:0] pack_cap();
    logic [63:0] r = '0;
    foreach (cap[i]) r = {r[55:0], cap[i]};
    return r;
  endfunction

  function automatic logic [63:0] pack_str(string s);
    logic [63:0] r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[55:0], s[i]};
    return r;
  endfunction

  // Scoreboard and model, evaluated mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      foreach (mdl_key[i]) mdl_key[i] = 8'h41;
      mdl_idx = 0;
      mdl_run = 0;
      mdl_err = 0;
      mdl_dec = 0;
    end else begin
      bit         acc;
      bit         cur_dec;
      logic [7:0] kd;
      check_eq("m_valid", 64'(bus_if.m_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0 && bus_if.m_valid)
        check_eq("m_last_data", 64'({bus_if.m_last, bus_if.m_data}), 64'(exp_q[0]));
      check_eq("s_ready", 64'(bus_if.s_ready), 64'((exp_q.size() == 0) || bus_if.m_ready));
      check_eq("busy", 64'(busy), 64'(mdl_run));
      check_eq("key_err", 64'(key_err), 64'(mdl_err));
      acc = bus_if.s_valid && ((exp_q.size() == 0) || bus_if.m_ready);
      if (exp_q.size() != 0 && bus_if.m_ready) begin
        cap.push_back(bus_if.m_data);
        void'(exp_q.pop_front());
      end
      if (key_wr_en) begin
        kd = key_wr_data;
        if (mdl_run || acc || key_wr_idx >= KeyLen) mdl_err = 1;
        else if (kd >= 8'd65 && kd <= 8'd90) mdl_key[key_wr_idx] = kd;
        else if (kd >= 8'd97 && kd <= 8'd122) mdl_key[key_wr_idx] = kd - 8'd32;
        else begin
          mdl_key[key_wr_idx] = 8'h41;
          mdl_err = 1;
        end
      end
      if (acc) begin
        cur_dec = mdl_run ? mdl_dec : mode;
        if (!mdl_run) mdl_dec = mode;
        exp_q.push_back({bus_if.s_last, ref_cipher(bus_if.s_data, mdl_key[mdl_idx], cur_dec)});
        if (is_letter(bus_if.s_data)) mdl_idx = (mdl_idx + 1) % KeyLen;
        if (bus_if.s_last) begin
          mdl_idx = 0;
          mdl_run = 0;
        end else begin
          mdl_run = 1;
        end
      end
    end
  end

  // All tasks start and end at posedge + 1
  task automatic rand_key_write();
    string pool = "AbZzq7 Kx";
    key_wr_en   = 1'b1;
    key_wr_idx  = IdxW'($urandom_range(0, 3));
    key_wr_data = pool[$urandom_range(0, pool.len() - 1)];
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int w = 0;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = b;
    bus_if.s_last  = l;
    if (rand_mix && $urandom_range(0, 7) == 0) rand_key_write();
    forever begin
      if (hold_n > 0) begin
        bus_if.m_ready = 1'b0;
        hold_n--;
      end else begin
        bus_if.m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (bus_if.s_ready) break;
      w++;
      @(posedge clk); #1;
      key_wr_en = 1'b0;
      if (w >= 60) begin
        check_eq("accept_timeout", 64'(w), 64'(0));
        break;
      end
    end
    @(posedge clk); #1;
    key_wr_en      = 1'b0;
    bus_if.s_valid = 1'b0;
    stalls += w;
  endtask

  task automatic drain();
    int n = 0;
    bus_if.m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic send_msg(input string s, input bit md, input int hold_at);
    cap.delete();
    stalls = 0;
    mode   = md;
    for (int i = 0; i < s.len(); i++) begin
      if (i == hold_at) hold_n = 3;
      send_byte(s[i], (i == s.len() - 1));
      if (i == 0) mode = 1'($urandom_range(0, 1));
      if (rand_mix && i != s.len() - 1 && $urandom_range(0, 3) == 0) begin
        bus_if.m_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) rand_key_write();
        @(posedge clk); #1;
        key_wr_en = 1'b0;
      end
    end
    drain();
  endtask

  task automatic write_key(input int idx, input logic [7:0] d);
    key_wr_en   = 1'b1;
    key_wr_idx  = IdxW'(idx);
    key_wr_data = d;
    @(posedge clk); #1;
    key_wr_en = 1'b0;
  endtask

  task automatic write_key_str(input string s);
    for (int i = 0; i < s.len(); i++) write_key(i, s[i]);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not complete");
  end

  initial begin
    string pool = "HeLLoworldXYZ !,.09";
    string msg;
    rst_n          = 1'b0;
    key_wr_en      = 1'b0;
    key_wr_idx     = '0;
    key_wr_data    = 8'h41;
    mode           = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = 8'h00;
    bus_if.s_last  = 1'b0;
    bus_if.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_m_valid", 64'(bus_if.m_valid), 64'(0));
    check_eq("rst_m_data", 64'(bus_if.m_data), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_key_err", 64'(key_err), 64'(0));
    @(posedge clk); #1;

    // Encrypt / decrypt round trip with key KEY
    write_key_str("KEY");
    send_msg("HeLlo", 1'b0, -1);
    check_eq("enc_HeLlo", pack_cap(), pack_str("RiJvs"));
    check_eq("enc_full_rate", 64'(stalls), 64'(0));
    send_msg("RiJvs", 1'b1, -1);
    check_eq("dec_RiJvs", pack_cap(), pack_str("HeLlo"));

    // Lowercase key bytes, non-letters pass and keep key position
    write_key_str("bbb");
    send_msg("a b!", 1'b0, -1);
    check_eq("enc_a_b", pack_cap(), pack_str("b c!"));

    // Three-cycle sink stall mid-message
    write_key_str("KEY");
    send_msg("HeLlo", 1'b0, 2);
    check_eq("bp_HeLlo", pack_cap(), pack_str("RiJvs"));
    check_eq("bp_stalls", 64'(stalls), 64'(3));

    // Key write while a message is running is dropped
    cap.delete();
    mode = 1'b0;
    send_byte("H", 1'b0);
    write_key(1, "Z");
    @(negedge clk);
    check_eq("err_run", 64'(key_err), 64'(1));
    @(posedge clk); #1;
    send_byte("e", 1'b1);
    drain();
    check_eq("run_write_dropped", pack_cap(), pack_str("Ri"));

    // Out-of-range index is dropped
    pulse_reset();
    write_key(3, "Q");
    @(negedge clk);
    check_eq("err_idx", 64'(key_err), 64'(1));
    @(posedge clk); #1;
    send_msg("Hi", 1'b0, -1);
    check_eq("idx3_dropped", pack_cap(), pack_str("Hi"));

    // Non-letter key byte stored as A
    pulse_reset();
    write_key(0, "7");
    write_key(1, "c");
    @(negedge clk);
    check_eq("err_digit", 64'(key_err), 64'(1));
    @(posedge clk); #1;
    send_msg("bb", 1'b0, -1);
    check_eq("digit_as_A", pack_cap(), pack_str("bd"));

    // Reset in the middle of a message
    pulse_reset();
    write_key_str("KEY");
    mode = 1'b0;
    send_byte("H", 1'b0);
    pulse_reset();
    @(negedge clk);
    check_eq("midrst_m_valid", 64'(bus_if.m_valid), 64'(0));
    check_eq("midrst_busy", 64'(busy), 64'(0));
    check_eq("midrst_key_err", 64'(key_err), 64'(0));
    @(posedge clk); #1;
    send_msg("Hi", 1'b0, -1);
    check_eq("midrst_identity", pack_cap(), pack_str("Hi"));

    // Randomised traffic, backpressure, gaps and key writes
    rdy_rand = 1;
    rand_mix = 1;
    for (int m = 0; m < 40; m++) begin
      if ($urandom_range(0, 9) == 0) pulse_reset();
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        rand_key_write();
        @(posedge clk); #1;
        key_wr_en = 1'b0;
      end
      msg = "";
      for (int i = 0; i < int'($urandom_range(1, 8)); i++)
        msg = {msg, string'(pool[$urandom_range(0, pool.len() - 1)])};
      send_msg(msg, 1'($urandom_range(0, 1)), -1);
    end
    rdy_rand = 0;
    rand_mix = 0;
    drain();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
    $finish;
  end

endmodule
